// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer: FSM states, register map,
// MODE codes and CTRL/STATUS bit positions.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2
    } ch_state_t;

    // Word offsets within a channel's 16-byte window (Addr[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PS_LSB   = 8;

    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_RUN_BIT  = 1;

endpackage

// File: rtl/multi_timer_if.sv
// Word-addressed bridge port of the timer plus its interrupt outputs.
interface multi_timer_if #(
    parameter int NUM_CH = 4
);
    logic [31:2]       Addr;
    logic              WE;
    logic [31:0]       Din;
    logic [31:0]       Dout;
    logic              IRQ;
    logic [NUM_CH-1:0] irq_vec;

    modport master (output Addr, WE, Din, input Dout, IRQ, irq_vec);
    modport slave  (input Addr, WE, Din, output Dout, IRQ, irq_vec);
endinterface

// File: rtl/multi_timer_ch.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler,
// IDLE->LOAD->CNT state machine and masked interrupt output.
module multi_timer_ch
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PS_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_ctrl,
    input  logic        we_preset,
    input  logic        we_status,
    input  logic [31:0] din,
    input  logic [1:0]  reg_sel,
    output logic [31:0] rd_data,
    output logic        irq
);

    ch_state_t        state_reg, state_next;
    logic             en_reg, en_next;
    logic [1:0]       mode_reg, mode_next;
    logic             im_reg, im_next;
    logic [PS_W-1:0]  ps_reg, ps_next;
    logic [PS_W-1:0]  presc_reg, presc_next;
    logic [CNT_W-1:0] preset_reg, preset_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             pend_reg, pend_next;
    logic             tick;
    logic             unused_din;

    assign tick       = (state_reg == ST_CNT) && en_reg && (presc_reg == ps_reg);
    assign unused_din = ^din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            en_reg     <= 1'b0;
            mode_reg   <= MODE_ONESHOT;
            im_reg     <= 1'b0;
            ps_reg     <= '0;
            presc_reg  <= '0;
            preset_reg <= '0;
            count_reg  <= '0;
            pend_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            en_reg     <= en_next;
            mode_reg   <= mode_next;
            im_reg     <= im_next;
            ps_reg     <= ps_next;
            presc_reg  <= presc_next;
            preset_reg <= preset_next;
            count_reg  <= count_next;
            pend_reg   <= pend_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        en_next     = en_reg;
        mode_next   = mode_reg;
        im_next     = im_reg;
        ps_next     = ps_reg;
        presc_next  = presc_reg;
        preset_next = preset_reg;
        count_next  = count_reg;
        pend_next   = pend_reg;

        // W1C is applied first so a same-cycle hardware set overrides it
        if (we_status && din[STAT_PEND_BIT]) begin
            pend_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (en_reg) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_next = preset_reg;
                presc_next = '0;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!en_reg) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    presc_next = '0;
                    if (count_reg > CNT_W'(1)) begin
                        count_next = count_reg - CNT_W'(1);
                    end else begin
                        pend_next = 1'b1;
                        if (mode_reg == MODE_RELOAD) begin
                            count_next = preset_reg;
                        end else begin
                            count_next = '0;
                            en_next    = 1'b0;
                            state_next = ST_IDLE;
                        end
                    end
                end else begin
                    presc_next = presc_reg + PS_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Bus writes come last so they override the hardware EN clear
        if (we_ctrl) begin
            en_next   = din[CTRL_EN_BIT];
            mode_next = din[CTRL_MODE_LSB +: 2];
            im_next   = din[CTRL_IM_BIT];
            ps_next   = din[CTRL_PS_LSB +: PS_W];
        end
        if (we_preset) begin
            preset_next = din[CNT_W-1:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT]           = en_reg;
                rd_data[CTRL_MODE_LSB +: 2]    = mode_reg;
                rd_data[CTRL_IM_BIT]           = im_reg;
                rd_data[CTRL_PS_LSB +: PS_W]   = ps_reg;
            end
            REG_PRESET: rd_data[CNT_W-1:0] = preset_reg;
            REG_COUNT:  rd_data[CNT_W-1:0] = count_reg;
            REG_STATUS: begin
                rd_data[STAT_PEND_BIT] = pend_reg;
                rd_data[STAT_RUN_BIT]  = (state_reg != ST_IDLE);
            end
            default: rd_data = '0;
        endcase
    end

    assign irq = pend_reg & im_reg;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: address decode, write fan-out, read mux and
// IRQ reduction over NUM_CH channel instances.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PS_W   = 8
) (
    input logic           clk,
    input logic           reset,
    multi_timer_if.slave  bus
);

    logic [1:0]        reg_sel;
    logic [2:0]        ch_sel;
    logic [31:0]       rd_data [NUM_CH];
    logic [NUM_CH-1:0] irq_bits;
    logic              unused_addr;

    assign reg_sel     = bus.Addr[3:2];
    assign ch_sel      = bus.Addr[6:4];
    assign unused_addr = ^bus.Addr[31:7];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ch_we;
            assign ch_we = bus.WE && (ch_sel == 3'(gi));

            multi_timer_ch #(
                .CNT_W (CNT_W),
                .PS_W  (PS_W)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .we_ctrl   (ch_we && (reg_sel == REG_CTRL)),
                .we_preset (ch_we && (reg_sel == REG_PRESET)),
                .we_status (ch_we && (reg_sel == REG_STATUS)),
                .din       (bus.Din),
                .reg_sel   (reg_sel),
                .rd_data   (rd_data[gi]),
                .irq       (irq_bits[gi])
            );
        end
    endgenerate

    // Unimplemented channel indices fall through to zero
    always_comb begin
        bus.Dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i)) begin
                bus.Dout = rd_data[i];
            end
        end
    end

    assign bus.irq_vec = irq_bits;
    assign bus.IRQ     = |irq_bits;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a 32-bit-counter instance and an 8-bit one.
module tb_multi_timer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    multi_timer_if #(.NUM_CH(4)) bus ();
    multi_timer_if #(.NUM_CH(4)) bus8 ();

    multi_timer #(.NUM_CH(4), .CNT_W(32), .PS_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multi_timer #(.NUM_CH(4), .CNT_W(8), .PS_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input bit n8, input logic [31:0] a, input logic [31:0] d);
        if (n8) begin
            bus8.Addr = a[31:2]; bus8.Din = d; bus8.WE = 1'b1;
        end else begin
            bus.Addr = a[31:2]; bus.Din = d; bus.WE = 1'b1;
        end
        @(negedge clk);
        bus.WE  = 1'b0;
        bus8.WE = 1'b0;
        $display("wr%0s addr=0x%02h data=0x%08h", n8 ? "8" : "", a, d);
    endtask

    task automatic rd(input bit n8, input logic [31:0] a, output logic [31:0] d);
        if (n8) begin
            bus8.Addr = a[31:2]; bus8.WE = 1'b0;
        end else begin
            bus.Addr = a[31:2]; bus.WE = 1'b0;
        end
        #1;
        d = n8 ? bus8.Dout : bus.Dout;
    endtask

    task automatic chk_rd(input bit n8, input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(n8, a, d);
        check(tag, d, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Addr = '0;  bus.WE = 1'b0;  bus.Din = '0;
        bus8.Addr = '0; bus8.WE = 1'b0; bus8.Din = '0;

        // Reset state
        #2;
        check("rst_irq", {31'b0, bus.IRQ}, 32'h0);
        check("rst_vec", {28'b0, bus.irq_vec}, 32'h0);
        chk_rd(0, "rst_ctrl0", 32'h00, 32'h0);
        chk_rd(0, "rst_stat0", 32'h0C, 32'h0);
        step(2);
        reset = 1'b1;
        step(1);

        // One-shot ch0: PRESET=5, PS=0, EN|IM
        wr(0, 32'h04, 32'd5);
        wr(0, 32'h00, 32'h9);
        step(2);
        chk_rd(0, "os_count_load", 32'h08, 32'd5);
        chk_rd(0, "os_run", 32'h0C, 32'h2);
        step(4);
        chk_rd(0, "os_count_last", 32'h08, 32'd1);
        check("os_irq_early", {31'b0, bus.IRQ}, 32'h0);
        step(1);
        check("os_irq", {31'b0, bus.IRQ}, 32'h1);
        chk_rd(0, "os_stat_done", 32'h0C, 32'h1);
        chk_rd(0, "os_ctrl_en0", 32'h00, 32'h8);
        chk_rd(0, "os_count_end", 32'h08, 32'd0);
        wr(0, 32'h0C, 32'h1);
        check("os_irq_clr", {31'b0, bus.IRQ}, 32'h0);

        // Auto-reload ch1: PRESET=3, PS=1 -> period 6
        wr(0, 32'h14, 32'd3);
        wr(0, 32'h10, 32'h10B);
        step(7);
        chk_rd(0, "ar_stat_pre", 32'h1C, 32'h2);
        step(1);
        chk_rd(0, "ar_stat_exp1", 32'h1C, 32'h3);
        check("ar_irq", {31'b0, bus.IRQ}, 32'h1);
        check("ar_vec", {28'b0, bus.irq_vec}, 32'h2);
        wr(0, 32'h1C, 32'h1);
        check("ar_irq_drop", {31'b0, bus.IRQ}, 32'h0);
        chk_rd(0, "ar_stat_w1c", 32'h1C, 32'h2);
        step(4);
        wr(0, 32'h1C, 32'h1);
        chk_rd(0, "ar_set_wins", 32'h1C, 32'h3);
        chk_rd(0, "ar_reload", 32'h18, 32'd3);
        wr(0, 32'h1C, 32'h1);
        step(4);
        chk_rd(0, "ar_stat_pre2", 32'h1C, 32'h2);
        step(1);
        chk_rd(0, "ar_period", 32'h1C, 32'h3);
        wr(0, 32'h10, 32'h0);
        wr(0, 32'h1C, 32'h1);
        chk_rd(0, "ar_stopped", 32'h1C, 32'h0);

        // Mask/vector on ch2
        wr(0, 32'h24, 32'd2);
        wr(0, 32'h20, 32'h1);
        step(4);
        chk_rd(0, "mask_pend", 32'h2C, 32'h1);
        check("mask_irq", {31'b0, bus.IRQ}, 32'h0);
        check("mask_vec", {28'b0, bus.irq_vec}, 32'h0);
        wr(0, 32'h20, 32'h8);
        check("unmask_irq", {31'b0, bus.IRQ}, 32'h1);
        check("unmask_vec", {28'b0, bus.irq_vec}, 32'h4);
        wr(0, 32'h2C, 32'h1);
        wr(0, 32'h20, 32'h0);
        check("mask_clean", {31'b0, bus.IRQ}, 32'h0);

        // Concurrency: ch0 one-shot 10, ch3 auto-reload 4 then PRESET->2
        wr(0, 32'h04, 32'd10);
        wr(0, 32'h34, 32'd4);
        wr(0, 32'h00, 32'h1);
        wr(0, 32'h30, 32'h3);
        step(2);
        wr(0, 32'h34, 32'd2);
        chk_rd(0, "conc_ch0_cnt", 32'h08, 32'd8);
        chk_rd(0, "conc_ch3_cnt", 32'h38, 32'd3);
        step(2);
        chk_rd(0, "conc_ch3_last", 32'h38, 32'd1);
        chk_rd(0, "conc_ch3_nopend", 32'h3C, 32'h2);
        step(1);
        chk_rd(0, "conc_new_preset", 32'h38, 32'd2);
        chk_rd(0, "conc_ch3_pend", 32'h3C, 32'h3);
        chk_rd(0, "conc_ch0_cnt2", 32'h08, 32'd5);
        wr(0, 32'h00, 32'h0);
        chk_rd(0, "abort_cnt", 32'h08, 32'd4);
        step(3);
        chk_rd(0, "abort_hold", 32'h08, 32'd4);
        chk_rd(0, "abort_idle", 32'h0C, 32'h0);
        wr(0, 32'h30, 32'h0);
        wr(0, 32'h3C, 32'h1);
        chk_rd(0, "conc_ch3_off", 32'h3C, 32'h0);

        // PRESET=0 expires after one tick
        wr(0, 32'h04, 32'd0);
        wr(0, 32'h00, 32'h1);
        step(2);
        chk_rd(0, "p0_run", 32'h0C, 32'h2);
        chk_rd(0, "p0_count", 32'h08, 32'd0);
        step(1);
        chk_rd(0, "p0_pend", 32'h0C, 32'h1);
        wr(0, 32'h0C, 32'h1);

        // CNT_W=8 full range, upper Din bits dropped
        wr(1, 32'h04, 32'h1FF);
        chk_rd(1, "w8_preset", 32'h04, 32'hFF);
        wr(1, 32'h00, 32'h1);
        step(2);
        chk_rd(1, "w8_count", 32'h08, 32'hFF);
        step(254);
        chk_rd(1, "w8_last", 32'h08, 32'd1);
        chk_rd(1, "w8_nopend", 32'h0C, 32'h2);
        step(1);
        chk_rd(1, "w8_pend", 32'h0C, 32'h1);
        chk_rd(1, "w8_zero", 32'h08, 32'd0);

        // Channel 5 does not exist
        wr(0, 32'h50, 32'hFFFF);
        wr(0, 32'h54, 32'h1234);
        chk_rd(0, "ch5_ctrl", 32'h50, 32'h0);
        chk_rd(0, "ch5_preset", 32'h54, 32'h0);
        chk_rd(0, "ch5_count", 32'h58, 32'h0);
        chk_rd(0, "ch1_preset_kept", 32'h14, 32'd3);
        chk_rd(0, "ch1_ctrl_kept", 32'h10, 32'h0);
        check("ch5_irq", {31'b0, bus.IRQ}, 32'h0);

        // Asynchronous reset mid-count
        wr(0, 32'h04, 32'd2);
        wr(0, 32'h00, 32'hB);
        step(4);
        check("ar2_irq", {31'b0, bus.IRQ}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("areset_irq", {31'b0, bus.IRQ}, 32'h0);
        check("areset_vec", {28'b0, bus.irq_vec}, 32'h0);
        chk_rd(0, "areset_ctrl", 32'h00, 32'h0);
        chk_rd(0, "areset_preset", 32'h04, 32'h0);
        chk_rd(0, "areset_stat", 32'h0C, 32'h0);
        step(1);
        reset = 1'b1;
        step(3);
        chk_rd(0, "post_rst_stat", 32'h0C, 32'h0);
        chk_rd(0, "post_rst_count", 32'h08, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised multi-channel down-counting timer/counter peripheral on the CPU's word-addressed memory-mapped bridge.
- NUM_CH independent channels, each with:
  - a CNT_W-bit counter
  - a per-channel prescaler
  - one-shot or auto-reload mode
  - a sticky write-1-to-clear pending flag
- Per-channel interrupts are masked and ORed onto one IRQ line for the CP0 external-interrupt input; the per-channel vector is also exported.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- CNT_W, 32, counter/preset width (8..32).
- PS_W, 8, prescaler width (1..16).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Addr  input  30 [31:2]  word address. Addr[3:2] selects the register; Addr[6:4] selects the channel.
- WE  input  1  write enable, one write per cycle.
- Din  input  32  write data.
- Dout  output  32  combinational read data for the addressed register.
- IRQ  output  1  OR over channels of (PEND & IM).
- irq_vec  output  NUM_CH  per-channel (PEND & IM).

Behaviour:
- Register map, channel base = ch*16:
  - 0x0 CTRL: [0] EN, [2:1] MODE, [3] IM, [8+PS_W-1:8] PS. Other bits read 0.
  - 0x4 PRESET: CNT_W bits, zero-extended on read.
  - 0x8 COUNT: read-only; writes ignored.
  - 0xC STATUS: [0] PEND (W1C), [1] RUN = (state != IDLE), read-only. Other bits read 0.
- MODE encoding: 00 one-shot, 01 auto-reload. 10 and 11 behave as 00.
- Channel index >= NUM_CH: reads return 0, writes are ignored.
- Reset: all registers 0, every channel IDLE, prescaler 0, IRQ = 0, irq_vec = 0. Reset asserted mid-count aborts immediately; no pending flag survives.
- Per-channel FSM: IDLE -> LOAD -> CNT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; prescaler <= 0; go to CNT.
  - CNT: if EN=0, go to IDLE and COUNT holds. Otherwise, on a tick:
    - if COUNT > 1: COUNT <= COUNT - 1.
    - else: PEND <= 1. In one-shot mode, COUNT <= 0, EN <= 0, go to IDLE. In auto-reload mode, COUNT <= PRESET and stay in CNT.
- Prescaler: tick is asserted when prescaler == PS, and the prescaler then wraps to 0; otherwise it increments. It runs only in CNT.
- Timing: PEND rises N*(PS+1) clock edges after the edge that entered CNT, where N = max(PRESET, 1).
  - PRESET = 0 behaves as PRESET = 1.
  - Auto-reload period is exactly N*(PS+1) cycles, with no dead cycle.
- Start latency: a write of EN=1 at edge t gives LOAD at t+1 and CNT at t+2.
- Bus writes affect only the addressed register. All other channels, and the other registers of the addressed channel, keep counting in the same cycle.
- Simultaneous events:
  - CTRL write and hardware EN-clear in the same cycle: the bus write wins.
  - PEND set by hardware and W1C in the same cycle: set wins.
  - PRESET written during CNT: used only at the next LOAD or reload.
  - PS written during CNT: takes effect at the next tick comparison.
- PEND is sticky regardless of IM. IM gates only IRQ/irq_vec, so unmasking with PEND=1 raises IRQ in the same cycle (combinational).
- Counter width: COUNT and PRESET are CNT_W bits. Din bits above CNT_W are dropped on write.

Decomposition:
- The shared constants header holds:
  - FSM state codes (IDLE/LOAD/CNT)
  - register offsets (CTRL/PRESET/COUNT/STATUS)
  - MODE codes
  - CTRL bit positions (EN, MODE, IM, PS field base)
- One sub-module, multi_timer_ch, implements one channel: registers, prescaler, FSM, and the PEND/irq output.
- The top level performs address decode, write-enable fan-out, the read mux, and the IRQ OR-reduction over a generate loop.

Test Plan:
- One-shot, ch0: PRESET=5, PS=0, CTRL=0x9 (EN, IM). Required response:
  - COUNT=5 two cycles after the write.
  - PEND/IRQ rise exactly 5 edges after entering CNT.
  - CTRL[0] reads 0 and RUN=0 afterwards.
- Auto-reload, ch1: PRESET=3, PS=1, MODE=01, IM=1. Required response:
  - PEND sets every 6 cycles.
  - W1C of STATUS clears PEND, and IRQ drops the next cycle.
  - A W1C in the same cycle as expiry leaves PEND=1.
- Mask/vector: ch2 expires with IM=0, giving PEND=1, IRQ=0 and irq_vec=0. Writing IM=1 gives IRQ=1 and irq_vec[2]=1 combinationally.
- Concurrency and abort:
  - ch0 and ch3 run simultaneously while PRESET of ch3 is rewritten mid-count.
  - The rewrite does not disturb the ch0 count, and the new ch3 PRESET is applied only on reload.
  - EN=0 mid-count freezes COUNT in IDLE.
- Boundaries:
  - PRESET=0 expires after 1 tick.
  - CNT_W=8 with PRESET=0xFF counts the full range.
  - Channel index 5 with NUM_CH=4 reads 0 and ignores writes.
  - Asserting reset (reset=0) asynchronously mid-count clears all registers and IRQ without waiting for clk.
